// File: rtl/dram_store_buffer.sv
// Posted-write FIFO between the store lane aligner and the DRAM write port.
// Drains stores in program order and flags loads that hit a pending store word.
module dram_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [3:0]               in_wmask,
    input  logic [31:0]              in_wdata,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    output logic [AW-1:0]            mem_waddr,
    output logic [3:0]               mem_wmask,
    output logic [31:0]              mem_wdata,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    // Handshake: a beat transfers on any edge where valid and ready are both
    // high; once mem_wvalid rises the head stays put until mem_wready takes it.
    logic [AW-3:0] addr_q [DEPTH];
    logic [3:0]    mask_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          unused_low;

    assign unused_low = ^{in_addr[1:0], ld_addr[1:0]};

    // Ready comes only from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign in_ready   = (count != FULL_COUNT);
    assign empty      = (count == '0);
    assign mem_wvalid = !empty;
    assign push       = in_valid && in_ready && (in_wmask != 4'b0000);
    assign pop        = mem_wvalid && mem_wready;

    assign mem_waddr = mem_wvalid ? {addr_q[rd_ptr], 2'b00} : '0;
    assign mem_wmask = mem_wvalid ? mask_q[rd_ptr] : 4'b0000;
    assign mem_wdata = mem_wvalid ? data_q[rd_ptr] : 32'h0;

    always_comb begin
        ld_hit = push && (in_addr[AW-1:2] == ld_addr[AW-1:2]);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == ld_addr[AW-1:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= in_addr[AW-1:2];
            mask_q[wr_ptr] <= in_wmask;
            data_q[wr_ptr] <= in_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= wr_ptr + 1'b1;
                valid_q[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + 1'b1;
                valid_q[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_store_buffer.sv
// Directed bench for dram_store_buffer: a small FIFO model with an expected
// queue predicts the head, occupancy and handshake flags every cycle.
module tb_dram_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int W     = 68;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [3:0]    in_wmask;
  logic [31:0]   in_wdata;
  logic          mem_wvalid;
  logic          mem_wready;
  logic [AW-1:0] mem_waddr;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic          empty;
  logic [2:0]    count;

  int n_vec = 0;
  int n_bad = 0;
  int m_count = 0;
  bit m_pushed;
  logic [W-1:0] exp_q[$];

  dram_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wmask(in_wmask), .in_wdata(in_wdata),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Checks the visible state against the model, then clocks one edge and
  // advances the model with the transfers that edge should perform.
  task automatic cycle();
    bit push;
    bit pop;
    logic [W-1:0] head;
    head = (m_count != 0) ? exp_q[0] : '0;
    check("in_ready", W'(in_ready), W'(m_count < DEPTH));
    check("mem_wvalid", W'(mem_wvalid), W'(m_count != 0));
    check("empty", W'(empty), W'(m_count == 0));
    check("count", W'(count), W'(m_count));
    check("head", {mem_waddr, mem_wmask, mem_wdata}, head);
    push = in_valid && (m_count < DEPTH) && (in_wmask != 4'b0000);
    pop  = (m_count != 0) && mem_wready;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_count  = 0;
      m_pushed = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({in_addr[AW-1:2], 2'b00, in_wmask, in_wdata});
      m_count  = m_count + int'(push) - int'(pop);
      m_pushed = push;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [3:0] m, input logic [31:0] d);
    in_valid = v;
    in_addr  = a;
    in_wmask = m;
    in_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 4'b0000, '0);
    mem_wready = 1'b0;
    ld_addr    = '0;
    #1;
    do_reset();

    // 1 + 3: reset state, single push, head held for 10 cycles, then one pop
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_ld_hit", W'(ld_hit), W'(0));
    check("rst_count", W'(count), W'(0));
    drive(1'b1, 32'h8000_0001, 4'b0010, 32'h0000_AB00);
    cycle();
    drive(1'b0, '0, 4'b0000, '0);
    check("t1_waddr", W'(mem_waddr), W'(32'h8000_0000));
    check("t1_wmask", W'(mem_wmask), W'(4'b0010));
    check("t1_wdata", W'(mem_wdata), W'(32'h0000_AB00));
    for (int i = 0; i < 10; i++) cycle();
    check("t3_hold", {mem_waddr, mem_wmask, mem_wdata}, {32'h8000_0000, 4'b0010, 32'h0000_AB00});
    mem_wready = 1'b1;
    cycle();
    mem_wready = 1'b0;
    check("t3_empty", W'(empty), W'(1));

    // 2: fill to DEPTH, hold a fifth beat, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h1000_0000 + 32'(i * 4), 4'b1111, 32'hA000_0000 + 32'(i));
      cycle();
    end
    check("t2_full_ready", W'(in_ready), W'(0));
    check("t2_full_count", W'(count), W'(4));
    drive(1'b1, 32'h1000_0040, 4'b1100, 32'hA000_0005);
    cycle();
    cycle();
    check("t2_held_count", W'(count), W'(4));
    mem_wready = 1'b1;
    m_pushed = 1'b0;
    for (int i = 0; i < 10 && !m_pushed; i++) cycle();
    check("t2_fifth_taken", W'(m_pushed), W'(1));
    drive(1'b0, '0, 4'b0000, '0);
    for (int i = 0; i < 10 && m_count != 0; i++) cycle();
    check("t2_drained", W'(empty), W'(1));
    mem_wready = 1'b0;

    // 4: steady push+pop at occupancy 2, pointers wrap several times
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h2000_0000 + 32'(i * 4), 4'b0001 << i, 32'hB000_0000 + 32'(i));
      cycle();
    end
    mem_wready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      drive(1'b1, 32'h2000_0000 + 32'(i * 4), 4'b0001 << (i % 4), 32'hB000_0000 + 32'(i));
      cycle();
      check("t4_count", W'(count), W'(2));
    end
    drive(1'b0, '0, 4'b0000, '0);
    cycle();
    cycle();
    mem_wready = 1'b0;
    check("t4_empty", W'(empty), W'(1));

    // 5: load hit detection at word granularity
    drive(1'b1, 32'h8000_0104, 4'b1111, 32'h1234_5678);
    cycle();
    drive(1'b0, '0, 4'b0000, '0);
    ld_addr = 32'h8000_0107;
    #1;
    check("t5_hit_same_word", W'(ld_hit), W'(1));
    ld_addr = 32'h8000_0108;
    #1;
    check("t5_miss_next_word", W'(ld_hit), W'(0));
    drive(1'b1, 32'h8000_0108, 4'b0000, 32'h0);
    #1;
    check("t5_zero_mask_push", W'(ld_hit), W'(0));
    drive(1'b1, 32'h8000_0108, 4'b0001, 32'h0000_0099);
    #1;
    check("t5_push_bypass_hit", W'(ld_hit), W'(1));
    cycle();
    drive(1'b0, '0, 4'b0000, '0);
    ld_addr    = 32'h8000_0104;
    mem_wready = 1'b1;
    #1;
    check("t5_hit_while_pop", W'(ld_hit), W'(1));
    cycle();
    #1;
    check("t5_after_pop", W'(ld_hit), W'(0));
    cycle();
    mem_wready = 1'b0;
    ld_addr    = '0;

    // 6: reset mid-handshake with 3 entries, then a zero-mask offer
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000_0000 + 32'(i * 4), 4'b1111, 32'hC000_0000 + 32'(i));
      cycle();
    end
    drive(1'b0, '0, 4'b0000, '0);
    mem_wready = 1'b1;
    do_reset();
    check("t6_wvalid", W'(mem_wvalid), W'(0));
    check("t6_count", W'(count), W'(0));
    check("t6_ready", W'(in_ready), W'(1));
    drive(1'b1, 32'h3000_0000, 4'b0000, 32'hDEAD_BEEF);
    cycle();
    drive(1'b0, '0, 4'b0000, '0);
    check("t6_mask0_count", W'(count), W'(0));
    cycle();
    check("t6_no_wvalid", W'(mem_wvalid), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
